// File: rtl/note_env_pkg.sv
// Shared types and helpers for the note envelope / PWM mixer.
//   env_state_t : per-voice envelope state encoding
//   clog2       : ceiling log2 for elaboration-time widths, clog2(1) = 0
package note_env_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/note_env_pwm_if.sv
// Control/audio bundle of the note envelope PWM mixer.
//   ena          : design enable, low forces pwm_out to 0
//   tone, gate   : per-voice square-wave tone and key-held flag
//   attack_rate  : level increment per envelope tick (0 = instant)
//   release_rate : level decrement per envelope tick (0 = instant)
//   pwm_out      : single-bit PWM audio stream
//   active       : per-voice "envelope not idle"
// master drives the controls, slave is the mixer.
interface note_env_pwm_if #(
  parameter int VOICES = 2
);
  logic              ena;
  logic [VOICES-1:0] tone;
  logic [VOICES-1:0] gate;
  logic [3:0]        attack_rate;
  logic [3:0]        release_rate;
  logic              pwm_out;
  logic [VOICES-1:0] active;

  modport master (
    output ena, tone, gate, attack_rate, release_rate,
    input  pwm_out, active
  );

  modport slave (
    input  ena, tone, gate, attack_rate, release_rate,
    output pwm_out, active
  );
endinterface

// File: rtl/env_gen.sv
// One voice's attack/sustain/release envelope.
//   clk, rst_n   : clock, synchronous active-low reset
//   tick         : one-cycle envelope step strobe
//   gate         : key held
//   attack_rate  : increment per tick while attacking (0 = jump to max)
//   release_rate : decrement per tick while releasing (0 = jump to 0)
//   level        : current envelope level
//   active       : state is not IDLE
module env_gen
  import note_env_pkg::*;
#(
  parameter int LEVEL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               gate,
  input  logic [3:0]         attack_rate,
  input  logic [3:0]         release_rate,
  output logic [LEVEL_W-1:0] level,
  output logic               active
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  env_state_t         state_reg, state_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic [LEVEL_W:0]   attack_sum;
  logic [LEVEL_W-1:0] release_step;

  // One extra bit so the saturation check sees the carry.
  assign attack_sum   = {1'b0, level_reg} + (LEVEL_W+1)'(attack_rate);
  assign release_step = LEVEL_W'(release_rate);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      level_reg <= '0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
    end
  end

  // A gate edge takes priority over the tick; a level step that reaches
  // its end point moves the state on the same edge.
  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    unique case (state_reg)
      IDLE: begin
        if (gate) state_next = ATTACK;
      end
      ATTACK: begin
        if (!gate) begin
          state_next = RELEASE;
        end else if (tick) begin
          if (attack_rate == 4'd0 || attack_sum >= {1'b0, LEVEL_MAX}) begin
            level_next = LEVEL_MAX;
            state_next = SUSTAIN;
          end else begin
            level_next = attack_sum[LEVEL_W-1:0];
          end
        end
      end
      SUSTAIN: begin
        level_next = LEVEL_MAX;
        if (!gate) state_next = RELEASE;
      end
      RELEASE: begin
        // Retrigger keeps the current level rather than restarting at 0.
        if (gate) begin
          state_next = ATTACK;
        end else if (tick) begin
          if (release_rate == 4'd0 || level_reg <= release_step) begin
            level_next = '0;
            state_next = IDLE;
          end else begin
            level_next = level_reg - release_step;
          end
        end
      end
      default: begin
        state_next = IDLE;
        level_next = '0;
      end
    endcase
  end

  assign level  = level_reg;
  assign active = (state_reg != IDLE);

endmodule

// File: rtl/note_env_pwm.sv
// Per-voice envelope shaping, voice mixing and PWM audio output.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : note_env_pwm_if slave (ena, tone, gate, rates in;
//                pwm_out, active out)
// A prescaler generates the envelope tick, each voice's square wave is
// gated by its envelope level, the levels are summed and the sum drives
// a free-running PWM comparator sampled once per PWM period.
module note_env_pwm
  import note_env_pkg::*;
#(
  parameter int VOICES  = 2,
  parameter int LEVEL_W = 8,
  parameter int ENV_DIV = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  note_env_pwm_if.slave  bus
);

  localparam int SW = LEVEL_W + clog2(VOICES);
  localparam int PW = clog2(ENV_DIV);

  logic [PW-1:0]      presc_reg;
  logic               tick;
  logic [LEVEL_W-1:0] level [VOICES];
  logic [VOICES-1:0]  active;
  logic [SW-1:0]      sum;
  logic [SW-1:0]      pcnt_reg;
  logic [SW-1:0]      sample_reg;
  logic               pwm_reg;

  assign tick = (presc_reg == PW'(ENV_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : gen_voice
      env_gen #(
        .LEVEL_W(LEVEL_W)
      ) u_env (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .gate        (bus.gate[gi]),
        .attack_rate (bus.attack_rate),
        .release_rate(bus.release_rate),
        .level       (level[gi]),
        .active      (active[gi])
      );
    end
  endgenerate

  // SW leaves room for VOICES full-scale levels, so the sum cannot wrap.
  always_comb begin
    sum = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (bus.tone[i]) sum = sum + SW'(level[i]);
    end
  end

  // The sample is latched at the top of each period so the duty cycle is
  // stable for a whole period; pcnt < sample never holds for every count,
  // so full scale stays just below 100 % duty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_reg   <= '0;
      sample_reg <= '0;
      pwm_reg    <= 1'b0;
    end else begin
      pcnt_reg <= pcnt_reg + SW'(1);
      if (pcnt_reg == '0) sample_reg <= sum;
      pwm_reg <= bus.ena & (pcnt_reg < sample_reg);
    end
  end

  assign bus.pwm_out = pwm_reg;
  assign bus.active  = active;

endmodule

// File: tb/tb_note_env_pwm.sv
// Randomized + directed bench for note_env_pwm (VOICES=2, LEVEL_W=8,
// ENV_DIV=4). The driver updates an integer reference model each cycle and
// queues the expected post-edge outputs; a monitor pops and compares.
module tb_note_env_pwm;

  localparam int VOICES  = 2;
  localparam int LEVEL_W = 8;
  localparam int ENV_DIV = 4;
  localparam int MAXL    = 255;
  localparam int PERIOD  = 512;

  localparam int S_IDLE = 0, S_ATT = 1, S_SUS = 2, S_REL = 3;

  typedef struct {
    bit       pwm;
    bit [1:0] act;
    int       lvl0;
    int       lvl1;
  } exp_t;

  logic clk;
  logic rst_n;
  note_env_pwm_if #(.VOICES(VOICES)) bus ();

  note_env_pwm #(
    .VOICES (VOICES),
    .LEVEL_W(LEVEL_W),
    .ENV_DIV(ENV_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   compared   = 0;
  int   mismatched = 0;
  int   hi_cnt     = 0;
  int   cyc        = 0;
  exp_t exp_q[$];

  // reference model state
  int st[VOICES];
  int lvl[VOICES];
  int presc, pcnt, smp;
  bit pwm_m;

  task automatic model_step();
    int sum;
    bit tk;
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        st[i]  = S_IDLE;
        lvl[i] = 0;
      end
      presc = 0; pcnt = 0; smp = 0; pwm_m = 0;
    end else begin
      tk  = (presc == ENV_DIV - 1);
      sum = 0;
      for (int i = 0; i < VOICES; i++) if (bus.tone[i]) sum += lvl[i];
      pwm_m = bus.ena && (pcnt < smp);
      if (pcnt == 0) smp = sum;
      pcnt  = (pcnt + 1) % PERIOD;
      presc = (presc + 1) % ENV_DIV;
      for (int i = 0; i < VOICES; i++) begin
        case (st[i])
          S_IDLE: if (bus.gate[i]) st[i] = S_ATT;
          S_ATT: begin
            if (!bus.gate[i]) st[i] = S_REL;
            else if (tk) begin
              if (bus.attack_rate == 0) lvl[i] = MAXL;
              else lvl[i] = (lvl[i] + bus.attack_rate > MAXL) ? MAXL : lvl[i] + bus.attack_rate;
              if (lvl[i] == MAXL) st[i] = S_SUS;
            end
          end
          S_SUS: if (!bus.gate[i]) st[i] = S_REL;
          default: begin
            if (bus.gate[i]) st[i] = S_ATT;
            else if (tk) begin
              if (bus.release_rate == 0) lvl[i] = 0;
              else lvl[i] = (lvl[i] < bus.release_rate) ? 0 : lvl[i] - bus.release_rate;
              if (lvl[i] == 0) st[i] = S_IDLE;
            end
          end
        endcase
      end
    end
    e.pwm  = pwm_m;
    e.act  = {st[1] != S_IDLE, st[0] != S_IDLE};
    e.lvl0 = lvl[0];
    e.lvl1 = lvl[1];
    exp_q.push_back(e);
  endtask

  // Model the coming edge with the inputs as they stand, then move to the
  // next negedge where the caller may change inputs again.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Gate changes are kept off tick edges.
  task automatic wait_no_tick();
    while (rst_n && presc == ENV_DIV - 1) step();
  endtask

  task automatic run_until_state(input int v, input int s);
    for (int k = 0; k < 400 && st[v] != s; k++) step();
  endtask

  task automatic duty_check(input string name, input int exp_hi);
    int c0;
    c0 = hi_cnt;
    run(PERIOD);
    compared++;
    if (hi_cnt - c0 != exp_hi) begin
      mismatched++;
      $display("FAIL duty %s: high %0d of %0d cycles, required %0d", name, hi_cnt - c0, PERIOD, exp_hi);
    end else begin
      $display("duty %s: high %0d of %0d cycles", name, hi_cnt - c0, PERIOD);
    end
  endtask

  // monitor
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      compared++;
      if (bus.pwm_out !== e.pwm || bus.active !== e.act ||
          dut.level[0] !== 8'(e.lvl0) || dut.level[1] !== 8'(e.lvl1)) begin
        mismatched++;
        $display("FAIL cycle %0d: pwm_out=%0b active=%b lvl=%0d/%0d, required pwm_out=%0b active=%b lvl=%0d/%0d",
                 cyc, bus.pwm_out, bus.active, dut.level[0], dut.level[1],
                 e.pwm, e.act, e.lvl0, e.lvl1);
      end
      if (bus.pwm_out === 1'b1) hi_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.tone = 2'b11;
    bus.gate = 2'b11;
    bus.attack_rate = 4'd15;
    bus.release_rate = 4'd5;
    @(negedge clk);

    // reset held with gates and tones high
    run(5);
    $display("phase reset: 5 cycles held");

    // attack to sustain on voice 0
    rst_n = 1'b1;
    bus.gate = 2'b01;
    bus.tone = 2'b01;
    run_until_state(0, S_SUS);
    run(1100);
    duty_check("sustain v0", 255);

    // release, then retrigger at 200
    wait_no_tick();
    bus.gate[0] = 1'b0;
    for (int k = 0; k < 400 && lvl[0] != 200; k++) step();
    $display("phase release: model level %0d", lvl[0]);
    wait_no_tick();
    bus.gate[0] = 1'b1;
    run_until_state(0, S_SUS);
    $display("phase retrigger: sustain reached");

    // instant release and attack
    bus.release_rate = 4'd0;
    wait_no_tick();
    bus.gate[0] = 1'b0;
    run_until_state(0, S_IDLE);
    bus.attack_rate = 4'd0;
    run(3);
    wait_no_tick();
    bus.gate[0] = 1'b1;
    run_until_state(0, S_SUS);
    $display("phase instant rates: done");

    // two-voice mix
    bus.attack_rate = 4'd15;
    wait_no_tick();
    bus.gate = 2'b11;
    bus.tone = 2'b11;
    run(1200);
    duty_check("mix tone=11", 510);
    bus.tone = 2'b01;
    run(1100);
    duty_check("mix tone=01", 255);

    // enable
    bus.ena = 1'b0;
    run(2);
    duty_check("ena off", 0);
    bus.ena = 1'b1;
    run(1100);
    duty_check("ena on", 255);

    // randomized stimulus with one mid-note reset
    for (int k = 0; k < 4000; k++) begin
      bus.tone = 2'($urandom);
      if (k == 2000) rst_n = 1'b0;
      if (k == 2003) rst_n = 1'b1;
      if ($urandom_range(0, 39) == 0 && !(rst_n && presc == ENV_DIV - 1))
        bus.gate[$urandom_range(0, 1)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0) bus.attack_rate = 4'($urandom);
      if ($urandom_range(0, 99) == 0) bus.release_rate = 4'($urandom);
      if ($urandom_range(0, 299) == 0) bus.ena = ~bus.ena;
      step();
    end
    $display("phase random: 4000 cycles");

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/note_env_pwm.md
Name: note_env_pwm

Overview:
- Downstream stage of the per-voice tone generators.
- Each voice's square-wave tone is scaled by its own attack/sustain/release envelope, driven by that voice's key gate.
- The scaled voices are summed and emitted as a single-bit PWM audio stream on one output pin.
- Replaces direct square-wave pin drive with a mixed, amplitude-shaped output.

Parameters:
- VOICES, 2, number of tone/gate input pairs (1..4)
- LEVEL_W, 8, envelope level width; full scale = 2^LEVEL_W-1
- ENV_DIV, 4096, clk cycles per envelope tick (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  design enable; low forces pwm_out=0
- tone  in  VOICES  square-wave tone per voice, clk-synchronous
- gate  in  VOICES  key-held per voice, clk-synchronous
- attack_rate  in  4  level increment per tick in ATTACK; 0 = instant
- release_rate  in  4  level decrement per tick in RELEASE; 0 = instant
- pwm_out  out  1  PWM audio output
- active  out  VOICES  voice i envelope state != IDLE

Behaviour:
- Reset and clock: rst_n, synchronous, active-low; clock clk.
- Reset values: all envelope states IDLE, all levels 0, prescaler 0, PWM counter 0, latched sample 0, pwm_out 0, active 0.
- Prescaler: counts 0..ENV_DIV-1 and wraps. tick=1 for one cycle when the count equals ENV_DIV-1.
- Per-voice envelope FSM:
  - States: IDLE, ATTACK, SUSTAIN, RELEASE. Level is unsigned LEVEL_W.
  - Transitions are evaluated every cycle. gate is sampled at the clock edge; the state changes at that same edge (1-cycle latency).
  - IDLE: gate=1 -> ATTACK.
  - ATTACK: gate=0 -> RELEASE. Otherwise, on tick: level += attack_rate, saturating at max. Reaching max -> SUSTAIN. attack_rate=0: level=max and -> SUSTAIN on the next tick.
  - SUSTAIN: level held at max. gate=0 -> RELEASE.
  - RELEASE: gate=1 -> ATTACK, keeping the current level (retrigger with no reset to 0). Otherwise, on tick: level -= release_rate, saturating at 0. Reaching 0 -> IDLE. release_rate=0: level=0 and -> IDLE on the next tick.
  - Level changes only on tick cycles. A state change and a level update in the same cycle use the old state's rule.
- Mixer:
  - sum = Σ (tone[i] ? level[i] : 0).
  - Width SW = LEVEL_W + clog2(VOICES), with clog2(1)=0. Defaults: SW=9, max sum 510.
  - No overflow is possible by construction.
- PWM:
  - SW-bit free-running counter pcnt.
  - When pcnt==0, sample_q <= sum. That sample is used for the whole period; period = 2^SW cycles.
  - pwm_out is registered: pwm_out <= ena & (pcnt < sample_q).
  - Full-scale sum never reaches 100% duty. Sum 0 gives a constant 0.
- ena=0: pwm_out=0 from the next cycle. Envelopes, prescaler and counter keep running.
- Reset asserted mid-note: all state returns to reset values on that edge, with no release tail.

Decomposition:
- Package note_env_pkg: env_state_t enum (IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3) and function clog2.
- Sub-module env_gen: one voice's FSM plus level register. Inputs: clk, rst_n, tick, gate, attack_rate, release_rate. Outputs: level, active.
- Instantiated VOICES times by a generate loop.
- Prescaler, summer and PWM counter live in the top.

Test Plan (ENV_DIV=4, LEVEL_W=8, VOICES=2 unless stated):
- Reset: hold rst_n=0 for 5 cycles with gate=2'b11 and tone=2'b11 -> pwm_out=0 and active=0 throughout; active[0]=1 one cycle after release of reset.
- Attack/sustain: gate[0]=1, attack_rate=15, tone[0]=1 constant -> level[0] = 15, 30, …, 240, then 255 on the 17th tick; state SUSTAIN; steady pwm_out duty 255/512.
- Release and retrigger:
  - After sustain, release_rate=5, gate[0]=0 -> level drops 5 per tick.
  - Set gate[0]=1 at level 200 -> ATTACK resumes from 200, not 0.
- Instant rates: attack_rate=0 -> level 255 one tick after gate. release_rate=0 -> level 0, active[0]=0 one tick after gate falls.
- Mix: both voices in SUSTAIN, tone=2'b11 -> sample_q=510, pwm_out high 510 of 512 cycles. tone=2'b01 -> 255 of 512.
- Enable: ena=0 during SUSTAIN -> pwm_out=0 next cycle, level unchanged. ena=1 -> duty resumes from the next edge.
